conv1d_engine: RTL and testbench

Parametrised 1-D convolution engine behind the standard CFU command/response handshake. It holds an input sample buffer, a kernel, and a full-precision output buffer. Each compute cycle produces LANES outputs of a zero-padded "same" convolution, with a programmable input offset. It supersedes the fixed 8-tap, 8-bit-output convolution block: the response is withheld until computation completes, and accumulators are read back at full width.

---
 rtl/conv1d_engine.sv | 175 +++++++++++++++++
 tb/tb_conv1d_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_engine.sv
// rtl/conv1d_engine.sv - 1-D zero-padded "same" convolution engine behind a CFU command/response handshake
// Computes LANES full-width outputs per compute cycle from int8 samples and int8 taps.
module conv1d_engine #(
  parameter int MAX_LEN    = 1024,
  parameter int KERNEL_LEN = 8,
  parameter int LANES      = 8,
  parameter int ACC_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);
  localparam int AW  = $clog2(MAX_LEN);
  localparam int LW  = AW + 1;
  localparam int KIW = $clog2(KERNEL_LEN);
  localparam int LSH = $clog2(LANES);

  localparam logic [6:0] F_CLEAR   = 7'd0;
  localparam logic [6:0] F_WR_IN   = 7'd1;
  localparam logic [6:0] F_WR_K    = 7'd2;
  localparam logic [6:0] F_RD_OUT  = 7'd3;
  localparam logic [6:0] F_SET_LEN = 7'd4;
  localparam logic [6:0] F_START   = 7'd5;
  localparam logic [6:0] F_SET_OFF = 7'd6;
  localparam logic [6:0] F_STATUS  = 7'd7;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RESP} state_t;

  state_t             state_q;
  logic [LW-1:0]      len_q;
  logic [LW-1:0]      grp_q;
  logic signed [8:0]  off_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;

  logic signed [7:0]       x_q   [MAX_LEN];
  logic signed [7:0]       w_q   [KERNEL_LEN];
  logic signed [ACC_W-1:0] out_q [MAX_LEN];

  logic [6:0]              funct7;
  logic [31:0]             op_a;
  logic                    cmd_fire;
  logic                    in_wr_ok;
  logic                    k_wr_ok;
  logic                    rd_ok;
  logic [AW-1:0]           in_base;
  logic [KIW-1:0]          k_base;
  logic [LW-1:0]           set_len;
  logic [LW-1:0]           g_total;
  logic [LW-1:0]           base;
  logic [31:0]             rd_val;
  logic signed [ACC_W-1:0] lane_acc [LANES];
  logic                    unused_fid;

  assign funct7     = cmd_payload_function_id[9:3];
  assign unused_fid = ^cmd_payload_function_id[2:0];
  assign op_a       = cmd_payload_inputs_0;
  assign cmd_ready  = (state_q == S_IDLE) && !reset;
  assign cmd_fire   = cmd_valid && cmd_ready;

  // Bounds are checked on 4A+3 in 34 bits so a huge A cannot wrap into range.
  assign in_wr_ok = {2'b00, op_a, 2'b11} < 34'(MAX_LEN);
  assign k_wr_ok  = {2'b00, op_a, 2'b11} < 34'(KERNEL_LEN);
  assign rd_ok    = op_a < 32'(MAX_LEN);
  assign in_base  = AW'({op_a, 2'b00});
  assign k_base   = KIW'({op_a, 2'b00});
  assign set_len  = (op_a > 32'(MAX_LEN)) ? LW'(MAX_LEN) : LW'(op_a);
  assign g_total  = LW'((len_q + LW'(LANES - 1)) >> LSH);
  assign base     = grp_q << LSH;
  assign rd_val   = rd_ok ? 32'(out_q[AW'(op_a)]) : 32'd0;

  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

  // Samples outside [0, len) are padding: they contribute zero and never see the offset.
  always_comb begin
    int j;
    logic signed [9:0]  s;
    logic signed [17:0] p;
    j = 0;
    s = '0;
    p = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_acc[l] = '0;
      for (int k = 0; k < KERNEL_LEN; k++) begin
        j = int'(base) + l + k - KERNEL_LEN / 2;
        if (j >= 0 && j < int'(len_q)) begin
          s           = 10'(x_q[AW'(j)]) + 10'(off_q);
          p           = w_q[KIW'(k)] * s;
          lane_acc[l] = lane_acc[l] + ACC_W'(p);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_fire && funct7 == F_WR_IN && in_wr_ok) begin
      for (int n = 0; n < 4; n++) x_q[in_base + AW'(n)] <= cmd_payload_inputs_1[31 - 8*n -: 8];
    end
    if (cmd_fire && funct7 == F_WR_K && k_wr_ok) begin
      for (int n = 0; n < 4; n++) w_q[k_base + KIW'(n)] <= cmd_payload_inputs_1[31 - 8*n -: 8];
    end
    if (state_q == S_COMPUTE && !reset) begin
      for (int l = 0; l < LANES; l++) begin
        if ((base + LW'(l)) < len_q) out_q[AW'(base + LW'(l))] <= lane_acc[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      grp_q       <= '0;
      off_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            grp_q       <= '0;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            case (funct7)
              F_CLEAR: begin
                len_q <= '0;
                off_q <= '0;
              end
              F_RD_OUT:  rsp_data_q <= rd_val;
              F_SET_LEN: begin
                len_q      <= set_len;
                rsp_data_q <= 32'(set_len);
              end
              F_START: begin
                if (len_q != '0) begin
                  state_q     <= S_COMPUTE;
                  rsp_valid_q <= 1'b0;
                  rsp_data_q  <= 32'(g_total);
                end
              end
              F_SET_OFF: off_q <= op_a[8:0];
              // busy is always 0 here: STATUS is only ever answered from IDLE
              F_STATUS:  rsp_data_q <= {15'd0, 1'b0, 16'(len_q)};
              default: ;
            endcase
          end
        end
        S_COMPUTE: begin
          if (grp_q == g_total - 1'b1) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            grp_q <= grp_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv1d_engine.sv
// tb/tb_conv1d_engine.sv - randomized self-checking bench for conv1d_engine
// A plain-arithmetic model of the command set supplies every expected response and latency.
module tb_conv1d_engine;
  localparam int MAX_LEN = 1024;
  localparam int K       = 8;
  localparam int LANES   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  always #5 clk = ~clk;

  conv1d_engine dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0   (cmd_payload_inputs_0),
    .cmd_payload_inputs_1   (cmd_payload_inputs_1),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_payload_outputs_0  (rsp_payload_outputs_0)
  );

  int n_vec = 0;
  int n_err = 0;

  int m_x [MAX_LEN];
  int m_w [K];
  int m_out [MAX_LEN];
  bit m_known [MAX_LEN];
  int m_len = 0;
  int m_off = 0;

  int dflt_exp [8] = '{20, 30, 42, 56, 72, 70, 66, 60};
  int off_exp  [8] = '{4, 5, 6, 7, 8, 7, 6, 5};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int ref_conv(input int i);
    int sum = 0;
    for (int k = 0; k < K; k++) begin
      int j = i + k - K / 2;
      if (j >= 0 && j < m_len) sum += m_w[k] * (m_x[j] + m_off);
    end
    return sum;
  endfunction

  task automatic model_cmd(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output int lat, output bit cmp);
    r   = 0;
    lat = 1;
    cmp = 1;
    case (f)
      7'd0: begin m_len = 0; m_off = 0; end
      7'd1: if (longint'(a) * 4 + 3 < MAX_LEN) begin
        for (int n = 0; n < 4; n++) begin
          byte bb;
          bb = b[31 - 8*n -: 8];
          m_x[int'(a) * 4 + n] = bb;
        end
      end
      7'd2: if (longint'(a) * 4 + 3 < K) begin
        for (int n = 0; n < 4; n++) begin
          byte bb;
          bb = b[31 - 8*n -: 8];
          m_w[int'(a) * 4 + n] = bb;
        end
      end
      7'd3: if (a < MAX_LEN) begin
        r   = m_out[a];
        cmp = m_known[a];
      end
      7'd4: begin
        m_len = (a > MAX_LEN) ? MAX_LEN : int'(a);
        r     = m_len;
      end
      7'd5: begin
        int g = (m_len + LANES - 1) / LANES;
        for (int i = 0; i < m_len; i++) begin
          m_out[i]   = ref_conv(i);
          m_known[i] = 1'b1;
        end
        r   = g;
        lat = (m_len > 0) ? g + 1 : 1;
      end
      7'd6: begin
        logic signed [8:0] o9;
        o9    = a[8:0];
        m_off = o9;
      end
      7'd7: r = m_len;
      default: r = 0;
    endcase
  endtask

  task automatic drive(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] r, output int lat);
    int w = 0;
    @(negedge clk);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {f, 3'($urandom)};
    cmd_payload_inputs_0    = a;
    cmd_payload_inputs_1    = b;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid            = 1'b0;
    cmd_payload_inputs_0 = $urandom;
    cmd_payload_inputs_1 = $urandom;
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (rsp_valid) break;
      check_val("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      if (lat >= 2000) begin
        check_val("rsp_timeout", 32'(rsp_valid), 32'd1);
        break;
      end
      rsp_ready = (hold == 0) ? 1'($urandom) : 1'b0;
      @(posedge clk);
      lat++;
    end
    r         = rsp_payload_outputs_0;
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      cmd_valid               = 1'b1;
      cmd_payload_function_id = {7'd7, 3'd0};
      @(posedge clk);
      @(negedge clk);
      check_val("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_payload", rsp_payload_outputs_0, r);
      check_val("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_val("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] r);
    logic [31:0] er;
    int          el;
    int          lat;
    bit          cmp;
    model_cmd(f, a, b, er, el, cmp);
    drive(f, a, b, hold, r, lat);
    if (cmp) check_val($sformatf("rsp f%0d a%0d", f, a), r, er);
    check_val($sformatf("latency f%0d", f), 32'(lat), 32'(el));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000ns");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    reset                   = 1'b1;
    cmd_valid               = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
    rsp_ready               = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_payload", rsp_payload_outputs_0, 32'd0);
    check_val("rst_cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    run_cmd(7'd7, 0, 0, 0, r);

    // fill every sample and tap, then compute the full buffer so all outputs are known
    for (int a = 0; a < MAX_LEN / 4; a++) run_cmd(7'd1, a, $urandom, 0, r);
    run_cmd(7'd2, 0, $urandom, 0, r);
    run_cmd(7'd2, 1, $urandom, 0, r);
    run_cmd(7'd4, MAX_LEN, 0, 0, r);
    run_cmd(7'd6, $urandom, 0, 0, r);
    run_cmd(7'd5, 0, 0, 0, r);
    check_val("full_groups", r, 32'd128);
    for (int i = 0; i < 32; i++) run_cmd(7'd3, $urandom_range(0, MAX_LEN - 1), 0, 0, r);

    // known-answer default case
    run_cmd(7'd0, 0, 0, 0, r);
    run_cmd(7'd1, 0, 32'h01020304, 0, r);
    run_cmd(7'd1, 1, 32'h05060708, 0, r);
    run_cmd(7'd2, 0, 32'h02020202, 0, r);
    run_cmd(7'd2, 1, 32'h02020202, 0, r);
    run_cmd(7'd4, 8, 0, 0, r);
    run_cmd(7'd7, 0, 0, 0, r);
    check_val("dflt_status", r, 32'd8);
    run_cmd(7'd5, 0, 0, 0, r);
    check_val("dflt_groups", r, 32'd1);
    for (int i = 0; i < 8; i++) begin
      run_cmd(7'd3, i, 0, 0, r);
      check_val($sformatf("dflt_out%0d", i), r, 32'(dflt_exp[i]));
    end

    // offset applies to real samples only, never to padding
    run_cmd(7'd1, 0, 32'h0, 0, r);
    run_cmd(7'd1, 1, 32'h0, 0, r);
    run_cmd(7'd2, 0, 32'h01010101, 0, r);
    run_cmd(7'd2, 1, 32'h01010101, 0, r);
    run_cmd(7'd6, 1, 0, 0, r);
    run_cmd(7'd5, 0, 0, 0, r);
    for (int i = 0; i < 8; i++) begin
      run_cmd(7'd3, i, 0, 0, r);
      check_val($sformatf("off_out%0d", i), r, 32'(off_exp[i]));
    end
    run_cmd(7'd1, 0, 32'h80808080, 0, r);
    run_cmd(7'd1, 1, 32'h80808080, 0, r);
    run_cmd(7'd6, 128, 0, 0, r);
    run_cmd(7'd5, 0, 0, 0, r);
    for (int i = 0; i < 8; i++) begin
      run_cmd(7'd3, i, 0, 0, r);
      check_val($sformatf("off128_out%0d", i), r, 32'd0);
    end

    // full-width accumulation
    run_cmd(7'd1, 0, 32'h7F7F7F7F, 0, r);
    run_cmd(7'd1, 1, 32'h7F7F7F7F, 0, r);
    run_cmd(7'd2, 0, 32'h80808080, 0, r);
    run_cmd(7'd2, 1, 32'h80808080, 0, r);
    run_cmd(7'd6, 0, 0, 0, r);
    run_cmd(7'd5, 0, 0, 0, r);
    run_cmd(7'd3, 4, 0, 0, r);
    check_val("width_out4", r, 32'hFFFE0400);

    // latency and back-pressure with len 20; out[20..23] must survive
    for (int a = 0; a < 8; a++) run_cmd(7'd1, a, $urandom, 0, r);
    run_cmd(7'd4, 32, 0, 0, r);
    run_cmd(7'd5, 0, 0, 0, r);
    run_cmd(7'd2, 0, $urandom, 0, r);
    run_cmd(7'd4, 20, 0, 0, r);
    run_cmd(7'd5, 0, 0, 5, r);
    check_val("bp_groups", r, 32'd3);
    for (int i = 16; i < 28; i++) run_cmd(7'd3, i, 0, 0, r);

    // boundaries
    run_cmd(7'd4, 5000, 0, 0, r);
    check_val("len_clamp", r, 32'd1024);
    run_cmd(7'd1, 256, $urandom, 0, r);
    run_cmd(7'd1, 32'h4000_0000, $urandom, 0, r);
    run_cmd(7'd2, 2, $urandom, 0, r);
    run_cmd(7'd4, 8, 0, 0, r);
    run_cmd(7'd5, 0, 0, 0, r);
    for (int i = 0; i < 8; i++) run_cmd(7'd3, i, 0, 0, r);
    run_cmd(7'd3, 1024, 0, 0, r);
    check_val("rd_oob", r, 32'd0);
    run_cmd(7'd9, 3, 3, 0, r);
    run_cmd(7'd4, 0, 0, 0, r);
    run_cmd(7'd5, 0, 0, 0, r);
    check_val("len0_start", r, 32'd0);

    // randomized lengths, offsets, kernels and sample patches
    for (int t = 0; t < 6; t++) begin
      int len = $urandom_range(1, 80);
      for (int a = 0; a < 6; a++) run_cmd(7'd1, $urandom_range(0, 24), $urandom, 0, r);
      run_cmd(7'd2, 0, $urandom, 0, r);
      run_cmd(7'd2, 1, $urandom, 0, r);
      run_cmd(7'd6, $urandom_range(0, 511), 0, 0, r);
      run_cmd(7'd4, len, 0, 0, r);
      run_cmd(7'd5, 0, 0, $urandom_range(0, 2), r);
      for (int i = 0; i < len + LANES; i++) run_cmd(7'd3, i, 0, 0, r);
    end

    // reset in the middle of a 64-sample computation
    run_cmd(7'd4, 64, 0, 0, r);
    @(negedge clk);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'd5, 3'd0};
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    m_len = 0;
    m_off = 0;
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    run_cmd(7'd7, 0, 0, 0, r);
    run_cmd(7'd4, 64, 0, 0, r);
    run_cmd(7'd6, $urandom_range(0, 511), 0, 0, r);
    run_cmd(7'd5, 0, 0, 0, r);
    for (int i = 0; i < 64; i++) run_cmd(7'd3, i, 0, 0, r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
